// File: rtl/ppu_spr_slot_sched.sv
// ---------------------------------------------------------------------------
// ppu_spr_slot_sched
//
// Per-scanline sprite slot scheduler for the PPU pixel pipeline. Each of the
// eight slots holds one sprite's X delay counter, two pattern shift registers,
// a palette, a priority bit and a remaining-pixel count. The slots count down
// X on every visible pixel and then shift out eight pixels, after which they
// are transparent until they are reloaded. The block also tracks the pixel X
// position on the current line and keeps the sticky sprite-0 hit flag.
//
// Ports
//   clk_i             single clock, all state updates on its rising edge
//   rst_i             synchronous active-high reset
//   pixel_en_i        one visible-pixel tick
//   line_start_i      start of visible scanline, sets pixel X to 0
//   load_en_i         slot load strobe
//   load_slot_i       slot index to load
//   load_x_i          sprite X delay
//   load_pat_lo_i     pattern plane 0 (MSB is the leftmost pixel)
//   load_pat_hi_i     pattern plane 1 (MSB is the leftmost pixel)
//   load_attr_i       attributes: [1:0] palette, [5] priority, [6] hflip
//   load_spr0_i       the sprite loaded into slot 0 is sprite 0
//   left_clip_i       suppress sprite-0 hits at X < 8
//   status_clear_i    clear the sticky hit flag
//   sprite_0_hit_i    raw hit from the pixel mux
//   spr_pal_idx_o     per slot {palette, hi bit, lo bit}, 0 when not active
//   spr_priority_o    per slot stored priority bit
//   slot_0_is_spr_0_o slot 0 currently holds sprite 0
//   spr0_hit_flag_o   sticky sprite-0 hit flag
//   spr_active_o      per slot: X delay elapsed and pixels left to shift
//
// Build option
//   PPU_SPR_HFLIP_EN  when defined, attr[6]=1 bit-reverses both patterns as
//                     they are loaded. When undefined attr[6] is ignored and
//                     the producer delivers already-flipped patterns.
// ---------------------------------------------------------------------------
module ppu_spr_slot_sched #(
    parameter int NUM_SLOTS = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pixel_en_i,
    input  logic       line_start_i,
    input  logic       load_en_i,
    input  logic [2:0] load_slot_i,
    input  logic [7:0] load_x_i,
    input  logic [7:0] load_pat_lo_i,
    input  logic [7:0] load_pat_hi_i,
    input  logic [7:0] load_attr_i,
    input  logic       load_spr0_i,
    input  logic       left_clip_i,
    input  logic       status_clear_i,
    input  logic       sprite_0_hit_i,
    output logic [3:0] spr_pal_idx_o [0:NUM_SLOTS-1],
    output logic       spr_priority_o [0:NUM_SLOTS-1],
    output logic       slot_0_is_spr_0_o,
    output logic       spr0_hit_flag_o,
    output logic [NUM_SLOTS-1:0] spr_active_o
);

    // -----------------------------------------------------------------------
    // Pattern data as it will be stored
    // -----------------------------------------------------------------------
    logic [7:0] pat_lo_load;
    logic [7:0] pat_hi_load;

`ifdef PPU_SPR_HFLIP_EN
    logic [7:0] pat_lo_rev;
    logic [7:0] pat_hi_rev;
    logic       unused_attr;

    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
        assign pat_lo_rev[gi] = load_pat_lo_i[7-gi];
        assign pat_hi_rev[gi] = load_pat_hi_i[7-gi];
    end

    assign pat_lo_load = load_attr_i[6] ? pat_lo_rev : load_pat_lo_i;
    assign pat_hi_load = load_attr_i[6] ? pat_hi_rev : load_pat_hi_i;
    assign unused_attr = ^{load_attr_i[7], load_attr_i[4:2]};
`else
    logic unused_attr;

    assign pat_lo_load = load_pat_lo_i;
    assign pat_hi_load = load_pat_hi_i;
    assign unused_attr = ^{load_attr_i[7:6], load_attr_i[4:2]};
`endif

    // -----------------------------------------------------------------------
    // Sprite slots
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        logic [7:0] x_cnt_reg;
        logic [7:0] pat_lo_reg;
        logic [7:0] pat_hi_reg;
        logic [1:0] pal_reg;
        logic       prio_reg;
        logic [3:0] remain_reg;
        logic       load_sel;
        logic       active;

        assign load_sel = load_en_i && (load_slot_i == 3'(gi));

        // A load on this slot takes precedence over a pixel step in the same
        // cycle; the step for this slot is simply lost.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                x_cnt_reg  <= 8'd0;
                pat_lo_reg <= 8'd0;
                pat_hi_reg <= 8'd0;
                pal_reg    <= 2'd0;
                prio_reg   <= 1'b0;
                remain_reg <= 4'd0;
            end else if (load_sel) begin
                x_cnt_reg  <= load_x_i;
                pat_lo_reg <= pat_lo_load;
                pat_hi_reg <= pat_hi_load;
                pal_reg    <= load_attr_i[1:0];
                prio_reg   <= load_attr_i[5];
                remain_reg <= 4'd8;
            end else if (pixel_en_i) begin
                if (x_cnt_reg != 8'd0) begin
                    x_cnt_reg <= x_cnt_reg - 8'd1;
                end else if (remain_reg != 4'd0) begin
                    pat_lo_reg <= {pat_lo_reg[6:0], 1'b0};
                    pat_hi_reg <= {pat_hi_reg[6:0], 1'b0};
                    remain_reg <= remain_reg - 4'd1;
                end
            end
        end

        // Output is taken from the current register state so the mux sees the
        // pixel of this tick without added latency.
        assign active             = (x_cnt_reg == 8'd0) && (remain_reg != 4'd0);
        assign spr_active_o[gi]   = active;
        assign spr_pal_idx_o[gi]  = active ? {pal_reg, pat_hi_reg[7], pat_lo_reg[7]} : 4'h0;
        assign spr_priority_o[gi] = prio_reg;
    end

    // -----------------------------------------------------------------------
    // Slot 0 sprite-0 marker
    // -----------------------------------------------------------------------
    logic slot0_spr0_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot0_spr0_reg <= 1'b0;
        end else if (load_en_i && (load_slot_i == 3'd0)) begin
            slot0_spr0_reg <= load_spr0_i;
        end
    end

    assign slot_0_is_spr_0_o = slot0_spr0_reg;

    // -----------------------------------------------------------------------
    // Pixel X position, saturating at 255 so the last column never wraps
    // back into the left-clip window.
    // -----------------------------------------------------------------------
    logic [7:0] pix_x_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_x_reg <= 8'd0;
        end else if (line_start_i) begin
            pix_x_reg <= 8'd0;
        end else if (pixel_en_i && (pix_x_reg != 8'hFF)) begin
            pix_x_reg <= pix_x_reg + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky sprite-0 hit. Hits in column 255 and, when clipping, in the
    // left 8 columns are ignored. A set beats a coincident clear.
    // -----------------------------------------------------------------------
    logic hit_set;
    logic hit_flag_reg;

    assign hit_set = pixel_en_i && sprite_0_hit_i && (pix_x_reg != 8'hFF)
                     && !(left_clip_i && (pix_x_reg < 8'd8));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_flag_reg <= 1'b0;
        end else if (hit_set) begin
            hit_flag_reg <= 1'b1;
        end else if (status_clear_i) begin
            hit_flag_reg <= 1'b0;
        end
    end

    assign spr0_hit_flag_o = hit_flag_reg;

endmodule

// File: tb/tb_ppu_spr_slot_sched.sv
// ---------------------------------------------------------------------------
// tb_ppu_spr_slot_sched
//
// Directed test for ppu_spr_slot_sched. Inputs are driven 1 time unit after
// the rising edge, outputs are sampled on the falling edge. Each comparison
// is an immediate assertion; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ppu_spr_slot_sched;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       pixel_en_i;
    logic       line_start_i;
    logic       load_en_i;
    logic [2:0] load_slot_i;
    logic [7:0] load_x_i;
    logic [7:0] load_pat_lo_i;
    logic [7:0] load_pat_hi_i;
    logic [7:0] load_attr_i;
    logic       load_spr0_i;
    logic       left_clip_i;
    logic       status_clear_i;
    logic       sprite_0_hit_i;
    logic [3:0] spr_pal_idx_o [0:7];
    logic       spr_priority_o [0:7];
    logic       slot_0_is_spr_0_o;
    logic       spr0_hit_flag_o;
    logic [7:0] spr_active_o;

    int n_assert = 0;
    int n_fail   = 0;

    ppu_spr_slot_sched #(.NUM_SLOTS(8)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .pixel_en_i        (pixel_en_i),
        .line_start_i      (line_start_i),
        .load_en_i         (load_en_i),
        .load_slot_i       (load_slot_i),
        .load_x_i          (load_x_i),
        .load_pat_lo_i     (load_pat_lo_i),
        .load_pat_hi_i     (load_pat_hi_i),
        .load_attr_i       (load_attr_i),
        .load_spr0_i       (load_spr0_i),
        .left_clip_i       (left_clip_i),
        .status_clear_i    (status_clear_i),
        .sprite_0_hit_i    (sprite_0_hit_i),
        .spr_pal_idx_o     (spr_pal_idx_o),
        .spr_priority_o    (spr_priority_o),
        .slot_0_is_spr_0_o (slot_0_is_spr_0_o),
        .spr0_hit_flag_o   (spr0_hit_flag_o),
        .spr_active_o      (spr_active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick(input int n);
        pixel_en_i = 1'b1;
        repeat (n) next_cycle();
        pixel_en_i = 1'b0;
    endtask

    task automatic load(input logic [2:0] slot, input logic [7:0] x, input logic [7:0] lo,
                        input logic [7:0] hi, input logic [7:0] attr, input logic spr0);
        load_en_i     = 1'b1;
        load_slot_i   = slot;
        load_x_i      = x;
        load_pat_lo_i = lo;
        load_pat_hi_i = hi;
        load_attr_i   = attr;
        load_spr0_i   = spr0;
    endtask

    initial begin
        logic [3:0] exp_a [0:3];
        exp_a[0] = 4'h0; exp_a[1] = 4'h0; exp_a[2] = 4'h0; exp_a[3] = 4'h9;

        rst_i = 1'b1; pixel_en_i = 1'b0; line_start_i = 1'b0; load_en_i = 1'b0;
        load_slot_i = 3'd0; load_x_i = 8'd0; load_pat_lo_i = 8'd0; load_pat_hi_i = 8'd0;
        load_attr_i = 8'd0; load_spr0_i = 1'b0; left_clip_i = 1'b0;
        status_clear_i = 1'b0; sprite_0_hit_i = 1'b0;

        // ---- reset state ----
        next_cycle(); next_cycle();
        @(negedge clk_i);
        chk("rst_active", spr_active_o, 8'h00);
        chk("rst_hit_flag", spr0_hit_flag_o, 1'b0);
        chk("rst_slot0_spr0", slot_0_is_spr_0_o, 1'b0);
        chk("rst_pal0", spr_pal_idx_o[0], 4'h0);
        rst_i = 1'b0;
        next_cycle();

        // ---- slot 2 X delay then shift ----
        load(3'd2, 8'd3, 8'h80, 8'h00, 8'h02, 1'b0);
        next_cycle();
        load_en_i = 1'b0;
        pixel_en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk($sformatf("a_pal2_tick%0d", i), spr_pal_idx_o[2], exp_a[i]);
            next_cycle();
        end
        @(negedge clk_i);
        chk("a_pal2_tick4", spr_pal_idx_o[2], 4'h8);
        chk("a_active2", spr_active_o[2], 1'b1);
        next_cycle();
        pixel_en_i = 1'b0;

        // ---- priority independent of active ----
        load(3'd5, 8'd200, 8'hFF, 8'hFF, 8'h20, 1'b0);
        next_cycle();
        load_en_i = 1'b0;
        @(negedge clk_i);
        chk("prio5", spr_priority_o[5], 1'b1);
        chk("prio5_inactive", spr_active_o[5], 1'b0);
        chk("prio5_pal", spr_pal_idx_o[5], 4'h0);
        next_cycle();

        // ---- slot 0, X=0, 8 pixels then transparent ----
        load(3'd0, 8'd0, 8'hFF, 8'hFF, 8'h03, 1'b1);
        next_cycle();
        load_en_i = 1'b0;
        @(negedge clk_i);
        chk("b_active_before_tick", spr_active_o[0], 1'b1);
        chk("b_slot0_spr0", slot_0_is_spr_0_o, 1'b1);
        next_cycle();
        pixel_en_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk($sformatf("b_pal0_tick%0d", i), spr_pal_idx_o[0], (i < 8) ? 4'hF : 4'h0);
            next_cycle();
        end
        pixel_en_i = 1'b0;
        @(negedge clk_i);
        chk("b_active0_done", spr_active_o[0], 1'b0);
        next_cycle();

        // ---- sprite-0 hit with left clip ----
        line_start_i = 1'b1;
        next_cycle();
        line_start_i = 1'b0;
        tick(5);                                  // X = 5
        left_clip_i = 1'b1; sprite_0_hit_i = 1'b1;
        tick(1);                                  // hit at X=5, clipped
        sprite_0_hit_i = 1'b0;
        @(negedge clk_i);
        chk("c_hit_x5_clipped", spr0_hit_flag_o, 1'b0);
        tick(2);                                  // X = 8
        sprite_0_hit_i = 1'b1;
        tick(1);                                  // hit at X=8
        sprite_0_hit_i = 1'b0;
        @(negedge clk_i);
        chk("c_hit_x8", spr0_hit_flag_o, 1'b1);
        next_cycle(); next_cycle();
        @(negedge clk_i);
        chk("c_hit_sticky", spr0_hit_flag_o, 1'b1);
        status_clear_i = 1'b1;
        next_cycle();
        status_clear_i = 1'b0;
        @(negedge clk_i);
        chk("c_hit_cleared", spr0_hit_flag_o, 1'b0);
        sprite_0_hit_i = 1'b1; status_clear_i = 1'b1;
        tick(1);                                  // set and clear together at X=9
        sprite_0_hit_i = 1'b0; status_clear_i = 1'b0;
        @(negedge clk_i);
        chk("c_set_beats_clear", spr0_hit_flag_o, 1'b1);
        status_clear_i = 1'b1;
        next_cycle();
        status_clear_i = 1'b0;
        left_clip_i = 1'b0;

        // ---- X=255 saturation and no hit ----
        line_start_i = 1'b1;
        next_cycle();
        line_start_i = 1'b0;
        tick(255);
        tick(3);                                  // must stay at 255
        sprite_0_hit_i = 1'b1;
        tick(1);
        sprite_0_hit_i = 1'b0;
        @(negedge clk_i);
        chk("d_no_hit_x255", spr0_hit_flag_o, 1'b0);
        line_start_i = 1'b1; pixel_en_i = 1'b1;   // line_start beats increment
        next_cycle();
        line_start_i = 1'b0; pixel_en_i = 1'b0;
        sprite_0_hit_i = 1'b1;
        tick(1);                                  // hit at X=0, no clip
        sprite_0_hit_i = 1'b0;
        @(negedge clk_i);
        chk("d_hit_after_line_start", spr0_hit_flag_o, 1'b1);
        status_clear_i = 1'b1;
        next_cycle();
        status_clear_i = 1'b0;

        // ---- load and pixel on the same cycle ----
        load(3'd3, 8'd2, 8'h80, 8'h00, 8'h00, 1'b0);
        next_cycle();
        load(3'd1, 8'd1, 8'h80, 8'h80, 8'h01, 1'b0);
        pixel_en_i = 1'b1;
        next_cycle();
        load_en_i = 1'b0; pixel_en_i = 1'b0;
        @(negedge clk_i);
        chk("e_active_1_3_wait", {spr_active_o[3], spr_active_o[1]}, 2'b00);
        tick(1);
        @(negedge clk_i);
        chk("e_active_1_3_go", {spr_active_o[3], spr_active_o[1]}, 2'b11);
        chk("e_pal1", spr_pal_idx_o[1], 4'h7);
        chk("e_pal3", spr_pal_idx_o[3], 4'h1);

        // ---- reset mid-line overrides load/pixel/clear ----
        sprite_0_hit_i = 1'b1;
        tick(1);
        sprite_0_hit_i = 1'b0;
        @(negedge clk_i);
        chk("f_hit_before_rst", spr0_hit_flag_o, 1'b1);
        rst_i = 1'b1; pixel_en_i = 1'b1;
        load(3'd4, 8'd0, 8'hFF, 8'hFF, 8'h23, 1'b0);
        next_cycle();
        rst_i = 1'b0; pixel_en_i = 1'b0; load_en_i = 1'b0;
        @(negedge clk_i);
        chk("f_rst_active", spr_active_o, 8'h00);
        chk("f_rst_pal1", spr_pal_idx_o[1], 4'h0);
        chk("f_rst_prio5", spr_priority_o[5], 1'b0);
        chk("f_rst_prio4", spr_priority_o[4], 1'b0);
        chk("f_rst_hit", spr0_hit_flag_o, 1'b0);
        chk("f_rst_slot0_spr0", slot_0_is_spr_0_o, 1'b0);
        next_cycle();

        // ---- horizontal flip option ----
        load(3'd6, 8'd0, 8'h01, 8'h00, 8'h40, 1'b0);
        next_cycle();
        load_en_i = 1'b0;
        @(negedge clk_i);
`ifdef PPU_SPR_HFLIP_EN
        chk("g_hflip_pal6", spr_pal_idx_o[6], 4'h1);
`else
        chk("g_noflip_pal6", spr_pal_idx_o[6], 4'h0);
`endif
        chk("g_active6", spr_active_o[6], 1'b1);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
